// File: rtl/mm_job_pkg.sv
// Shared types and helpers for the matrix-multiply job controller.
package mm_job_pkg;

  // Ownership of one ping-pong operand bank.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    QUEUED = 2'd1,
    ACTIVE = 2'd2
  } bank_state_t;

  // Job sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  // Word-address width for a bank of the given depth (at least one bit).
  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mm_job_ctrl_if.sv
// Host, engine and completion signals of the job controller.
interface mm_job_ctrl_if #(
  parameter int N_CH   = 2,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 8,
  parameter int RES_W  = 128
);
  logic                     ld_valid;
  logic                     ld_ready;
  logic                     ld_sel;
  logic [ADDR_W-1:0]        ld_addr;
  logic [N_CH*LANE_W-1:0]   ld_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     eng_start;
  logic                     eng_done;
  logic [N_CH*ADDR_W-1:0]   eng_raddr_a;
  logic [N_CH*ADDR_W-1:0]   eng_raddr_b;
  logic [N_CH*LANE_W-1:0]   eng_rdata_a;
  logic [N_CH*LANE_W-1:0]   eng_rdata_b;
  logic                     eng_wr_en;
  logic [RES_W-1:0]         eng_wdata;
  logic                     eng_stall;
  logic                     res_valid;
  logic                     res_ready;
  logic [RES_W-1:0]         res_data;
  logic                     done_valid;
  logic                     done_ready;
  logic                     done_bank;
  logic                     err_ovf;
  logic                     err_ld;
  logic                     busy;

  // Controller side.
  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, cmd_valid, eng_done,
           eng_raddr_a, eng_raddr_b, eng_wr_en, eng_wdata, res_ready, done_ready,
    output ld_ready, cmd_ready, eng_start, eng_rdata_a, eng_rdata_b, eng_stall,
           res_valid, res_data, done_valid, done_bank, err_ovf, err_ld, busy
  );

  // Host plus engine side.
  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, cmd_valid, eng_done,
           eng_raddr_a, eng_raddr_b, eng_wr_en, eng_wdata, res_ready, done_ready,
    input  ld_ready, cmd_ready, eng_start, eng_rdata_a, eng_rdata_b, eng_stall,
           res_valid, res_data, done_valid, done_bank, err_ovf, err_ld, busy
  );
endinterface

// File: rtl/mm_res_fifo.sv
// Result FIFO between engine and host: wrap-bit pointers, fall-through head.
module mm_res_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [DEPTH];
  logic [PW:0]  wr_ptr_r;
  logic [PW:0]  rd_ptr_r;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign pop_ok_s  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign drop      = push & full & ~pop_ok_s;
  assign count     = wr_ptr_r - rd_ptr_r;
  assign rdata     = empty ? {W{1'b0}} : mem_r[rd_ptr_r[PW-1:0]];

  // Advance the read and write pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Store accepted result words; storage itself is not reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mm_job_ctrl.sv
// Job controller: ping-pong operand banks, job sequencing, result FIFO.
module mm_job_ctrl
  import mm_job_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int LANE_W    = 32,
  parameter int DEPTH     = 256,
  parameter int RES_W     = 128,
  parameter int RES_DEPTH = 8
) (
  input logic          clock,
  input logic          reset_n,
  mm_job_ctrl_if.slave bus
);
  localparam int ADDR_W = addr_w_f(DEPTH);
  localparam int DW     = N_CH * LANE_W;
  localparam int CNT_W  = $clog2(RES_DEPTH) + 1;

  logic [DW-1:0]     mem_a_r [2][DEPTH];
  logic [DW-1:0]     mem_b_r [2][DEPTH];
  logic [ADDR_W-1:0] raddr_a_s [N_CH];
  logic [ADDR_W-1:0] raddr_b_s [N_CH];
  logic [DW-1:0]     rdata_a_r;
  logic [DW-1:0]     rdata_b_r;

  bank_state_t bank_r [2];
  bank_state_t bank_nxt_s [2];
  fsm_t        state_r;
  fsm_t        state_nxt_s;
  logic        fill_ptr_r;
  logic        fill_nxt_s;
  logic        older_s;
  logic        run_bank_r;
  logic        run_bank_nxt_s;
  logic        start_s;
  logic        eng_start_r;
  logic        fill_free_r;
  logic        busy_r;
  logic        done_valid_r;
  logic        done_bank_r;
  logic        err_ld_r;
  logic        err_ovf_r;
  logic        ld_fire_s;
  logic        cmd_fire_s;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_drop_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [RES_W-1:0] fifo_rdata_s;

  assign ld_fire_s  = bus.ld_valid & fill_free_r;
  assign cmd_fire_s = bus.cmd_valid & fill_free_r;
  assign older_s    = ~fill_ptr_r;

  // Bank ownership, fill pointer and job sequencing decisions.
  always_comb begin
    bank_nxt_s     = bank_r;
    fill_nxt_s     = fill_ptr_r;
    state_nxt_s    = state_r;
    run_bank_nxt_s = run_bank_r;
    start_s        = 1'b0;
    if (cmd_fire_s) begin
      bank_nxt_s[fill_ptr_r] = QUEUED;
      fill_nxt_s             = ~fill_ptr_r;
    end else begin
      fill_nxt_s = fill_ptr_r;
    end
    case (state_r)
      IDLE: begin
        if (bank_r[older_s] == QUEUED) begin
          run_bank_nxt_s      = older_s;
          bank_nxt_s[older_s] = ACTIVE;
          start_s             = 1'b1;
          state_nxt_s         = RUN;
        end else if (bank_r[fill_ptr_r] == QUEUED) begin
          run_bank_nxt_s         = fill_ptr_r;
          bank_nxt_s[fill_ptr_r] = ACTIVE;
          start_s                = 1'b1;
          state_nxt_s            = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (bus.eng_done) state_nxt_s = DRAIN;
        else              state_nxt_s = RUN;
      end
      DRAIN: begin
        // Completion is only reported once the host has taken every result.
        if (fifo_count_s == {CNT_W{1'b0}}) state_nxt_s = DONE;
        else                               state_nxt_s = DRAIN;
      end
      DONE: begin
        if (bus.done_ready) begin
          bank_nxt_s[run_bank_r] = FREE;
          state_nxt_s            = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state plus registered status outputs derived from next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_r[0]    <= FREE;
      bank_r[1]    <= FREE;
      state_r      <= IDLE;
      fill_ptr_r   <= 1'b0;
      run_bank_r   <= 1'b0;
      eng_start_r  <= 1'b0;
      fill_free_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_valid_r <= 1'b0;
      done_bank_r  <= 1'b0;
      err_ld_r     <= 1'b0;
      err_ovf_r    <= 1'b0;
    end else begin
      bank_r       <= bank_nxt_s;
      state_r      <= state_nxt_s;
      fill_ptr_r   <= fill_nxt_s;
      run_bank_r   <= run_bank_nxt_s;
      eng_start_r  <= start_s;
      fill_free_r  <= (bank_nxt_s[fill_nxt_s] == FREE);
      busy_r       <= (bank_nxt_s[0] != FREE) | (bank_nxt_s[1] != FREE);
      done_valid_r <= (state_nxt_s == DONE);
      done_bank_r  <= (state_nxt_s == DONE) & run_bank_nxt_s;
      err_ld_r     <= err_ld_r | (bus.ld_valid & ~fill_free_r);
      err_ovf_r    <= err_ovf_r | fifo_drop_s;
    end
  end

  // Host operand writes land in the current fill bank.
  always_ff @(posedge clock) begin
    if (ld_fire_s) begin
      if (bus.ld_sel) mem_b_r[fill_ptr_r][bus.ld_addr] <= bus.ld_data;
      else            mem_a_r[fill_ptr_r][bus.ld_addr] <= bus.ld_data;
    end
  end

  // Split the packed per-lane read addresses; lane 0 sits in the MSBs.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      raddr_a_s[c] = bus.eng_raddr_a[(N_CH-1-c)*ADDR_W +: ADDR_W];
      raddr_b_s[c] = bus.eng_raddr_b[(N_CH-1-c)*ADDR_W +: ADDR_W];
    end
  end

  // Registered per-lane operand reads from the running bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_a_r <= {DW{1'b0}};
      rdata_b_r <= {DW{1'b0}};
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        rdata_a_r[(N_CH-1-c)*LANE_W +: LANE_W] <=
          mem_a_r[run_bank_r][raddr_a_s[c]][(N_CH-1-c)*LANE_W +: LANE_W];
        rdata_b_r[(N_CH-1-c)*LANE_W +: LANE_W] <=
          mem_b_r[run_bank_r][raddr_b_s[c]][(N_CH-1-c)*LANE_W +: LANE_W];
      end
    end
  end

  mm_res_fifo #(
    .W     (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (bus.eng_wr_en),
    .pop     (bus.res_ready),
    .wdata   (bus.eng_wdata),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .drop    (fifo_drop_s),
    .count   (fifo_count_s)
  );

  assign bus.ld_ready    = fill_free_r;
  assign bus.cmd_ready   = fill_free_r;
  assign bus.eng_start   = eng_start_r;
  assign bus.eng_rdata_a = rdata_a_r;
  assign bus.eng_rdata_b = rdata_b_r;
  assign bus.eng_stall   = fifo_full_s;
  assign bus.res_valid   = ~fifo_empty_s;
  assign bus.res_data    = fifo_rdata_s;
  assign bus.done_valid  = done_valid_r;
  assign bus.done_bank   = done_bank_r;
  assign bus.err_ovf     = err_ovf_r;
  assign bus.err_ld      = err_ld_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mm_job_ctrl.sv
// Randomised bench for mm_job_ctrl against a bank/queue reference model.
module tb_mm_job_ctrl;
  import mm_job_pkg::*;

  localparam int N_CH      = 2;
  localparam int LANE_W    = 32;
  localparam int DEPTH     = 256;
  localparam int RES_W     = 128;
  localparam int RES_DEPTH = 8;
  localparam int ADDR_W    = addr_w_f(DEPTH);
  localparam int DW        = N_CH * LANE_W;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mm_job_ctrl_if #(.N_CH(N_CH), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .RES_W(RES_W)) bus ();

  mm_job_ctrl #(
    .N_CH(N_CH), .LANE_W(LANE_W), .DEPTH(DEPTH), .RES_W(RES_W), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: bank contents, result queue, sticky overflow.
  logic [DW-1:0]    ref_a [2][DEPTH];
  logic [DW-1:0]    ref_b [2][DEPTH];
  logic [RES_W-1:0] ref_q [$];
  int               ref_fill = 0;
  bit               ref_ovf  = 1'b0;
  int               addr_pool [5] = '{0, 1, 2, 3, DEPTH-1};

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i += 32) w[i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [RES_W-1:0] rand_res();
    logic [RES_W-1:0] w;
    for (int i = 0; i < RES_W; i += 32) w[i +: 32] = $urandom;
    return w;
  endfunction

  // Lane c of the result is lane c of the word at lane c's address.
  function automatic logic [DW-1:0] exp_read(input bit is_b, input int bank, input int addr [N_CH]);
    logic [DW-1:0] r;
    logic [DW-1:0] w;
    for (int c = 0; c < N_CH; c++) begin
      w = is_b ? ref_b[bank][addr[c]] : ref_a[bank][addr[c]];
      r[(N_CH-1-c)*LANE_W +: LANE_W] = w[(N_CH-1-c)*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  task automatic load(input bit sel, input int addr, input logic [DW-1:0] data);
    check_val("ld_ready", bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr[ADDR_W-1:0];
    bus.ld_data  = data;
    tick();
    bus.ld_valid = 1'b0;
    if (sel) ref_b[ref_fill][addr] = data;
    else     ref_a[ref_fill][addr] = data;
  endtask

  task automatic fill_pool();
    for (int i = 0; i < 5; i++) begin
      load(1'b0, addr_pool[i], rand_word());
      load(1'b1, addr_pool[i], rand_word());
    end
  endtask

  task automatic commit();
    check_val("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    ref_fill ^= 1;
  endtask

  task automatic read_check(input int bank, input int aa [N_CH], input int ba [N_CH], input string tag);
    for (int c = 0; c < N_CH; c++) begin
      bus.eng_raddr_a[(N_CH-1-c)*ADDR_W +: ADDR_W] = aa[c][ADDR_W-1:0];
      bus.eng_raddr_b[(N_CH-1-c)*ADDR_W +: ADDR_W] = ba[c][ADDR_W-1:0];
    end
    tick();
    check_val({tag, "_a"}, bus.eng_rdata_a, exp_read(1'b0, bank, aa));
    check_val({tag, "_b"}, bus.eng_rdata_b, exp_read(1'b1, bank, ba));
  endtask

  task automatic random_reads(input int bank, input int n);
    int aa [N_CH];
    int ba [N_CH];
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        aa[c] = addr_pool[$urandom_range(0, 4)];
        ba[c] = addr_pool[$urandom_range(0, 4)];
      end
      read_check(bank, aa, ba, "rd_rand");
    end
  endtask

  task automatic push(input logic [RES_W-1:0] data);
    bus.eng_wr_en = 1'b1;
    bus.eng_wdata = data;
    tick();
    bus.eng_wr_en = 1'b0;
    if (ref_q.size() < RES_DEPTH) ref_q.push_back(data);
    else                          ref_ovf = 1'b1;
  endtask

  task automatic pop_check();
    check_val("res_valid", bus.res_valid, 1);
    check_val("res_data", bus.res_data, ref_q[0]);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    void'(ref_q.pop_front());
  endtask

  task automatic pulse_done();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check_val(tag, bus.done_valid, 1);
  endtask

  task automatic ack_done();
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  initial begin
    int aa [N_CH];
    int ba [N_CH];
    int n;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cmd_valid = 1'b0; bus.eng_done = 1'b0; bus.eng_raddr_a = '0; bus.eng_raddr_b = '0;
    bus.eng_wr_en = 1'b0; bus.eng_wdata = '0; bus.res_ready = 1'b0; bus.done_ready = 1'b0;

    // Reset state
    #7;
    check_val("rst_ld_ready", bus.ld_ready, 0);
    check_val("rst_cmd_ready", bus.cmd_ready, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_eng_start", bus.eng_start, 0);
    check_val("rst_res_valid", bus.res_valid, 0);
    check_val("rst_done_valid", bus.done_valid, 0);
    check_val("rst_err", {bus.err_ld, bus.err_ovf, bus.eng_stall}, 0);
    #5 reset_n = 1'b1;
    tick(); tick();
    check_val("idle_ld_ready", bus.ld_ready, 1);
    check_val("idle_busy", bus.busy, 0);

    // Job 1 on bank 0
    fill_pool();
    commit();
    check_val("start_not_yet", bus.eng_start, 0);
    check_val("busy_after_commit", bus.busy, 1);
    tick();
    check_val("eng_start", bus.eng_start, 1);
    aa = '{2, 3};
    ba = '{3, 2};
    read_check(0, aa, ba, "rd_plan");
    check_val("start_one_cycle", bus.eng_start, 0);
    random_reads(0, 6);

    // Load and queue bank 1 while bank 0 runs
    fill_pool();
    commit();
    check_val("third_cmd_ready", bus.cmd_ready, 0);
    check_val("both_busy_ld_ready", bus.ld_ready, 0);

    // Illegal write into the running bank is ignored but flagged
    bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 2; bus.ld_data = ~ref_a[0][2];
    tick();
    bus.ld_valid = 1'b0;
    check_val("err_ld", bus.err_ld, 1);
    check_val("no_restart", bus.eng_start, 0);
    aa = '{2, 2};
    ba = '{2, 2};
    read_check(0, aa, ba, "rd_after_bad_ld");

    // Fill the result FIFO past capacity
    for (int i = 0; i < 10; i++) begin
      push(rand_res());
      if (i == 0) check_val("fwft_head", bus.res_data, ref_q[0]);
      if (i == 6) check_val("stall_7", bus.eng_stall, 0);
      if (i == 7) check_val("stall_8", bus.eng_stall, 1);
      if (i == 7) check_val("ovf_8", bus.err_ovf, 0);
      if (i == 8) check_val("ovf_9", bus.err_ovf, ref_ovf);
    end
    pulse_done();
    tick();
    check_val("drain_wait", bus.done_valid, 0);
    while (ref_q.size() > 0) begin
      pop_check();
      if (ref_q.size() == 7) check_val("stall_drop", bus.eng_stall, 0);
      if (ref_q.size() > 0)  check_val("drain_hold", bus.done_valid, 0);
    end
    wait_done("done1");
    check_val("done_bank0", bus.done_bank, 0);
    ack_done();
    check_val("done_clear", bus.done_valid, 0);
    check_val("ld_ready_bank0", bus.ld_ready, 1);
    n = 0;
    while (bus.eng_start !== 1'b1 && n < 2) begin
      tick();
      n++;
    end
    check_val("start_bank1", bus.eng_start, 1);

    // Job 2 on bank 1 with three unread results at eng_done
    random_reads(1, 6);
    for (int i = 0; i < 3; i++) push(rand_res());
    pulse_done();
    tick(); tick();
    check_val("drain3_wait", bus.done_valid, 0);
    while (ref_q.size() > 0) begin
      pop_check();
      if (ref_q.size() > 0) check_val("drain3_hold", bus.done_valid, 0);
    end
    wait_done("done2");
    check_val("done_bank1", bus.done_bank, 1);
    check_val("err_ovf_sticky", bus.err_ovf, ref_ovf);
    ack_done();
    check_val("busy_clear", bus.busy, 0);

    // eng_done while idle is ignored
    pulse_done();
    tick(); tick();
    check_val("idle_done_ignored", bus.done_valid, 0);
    check_val("idle_no_start", bus.eng_start, 0);

    // Asynchronous reset in the middle of a job
    load(1'b0, 5, rand_word());
    commit();
    tick();
    check_val("start_job3", bus.eng_start, 1);
    for (int i = 0; i < 9; i++) push(rand_res());
    check_val("ovf_before_rst", bus.err_ovf, 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_busy", bus.busy, 0);
    check_val("arst_res_valid", bus.res_valid, 0);
    check_val("arst_err_ovf", bus.err_ovf, 0);
    check_val("arst_err_ld", bus.err_ld, 0);
    check_val("arst_stall", bus.eng_stall, 0);
    check_val("arst_start", bus.eng_start, 0);
    #3 reset_n = 1'b1;
    ref_q.delete();
    tick(); tick();
    check_val("post_rst_ld_ready", bus.ld_ready, 1);
    check_val("post_rst_res_valid", bus.res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
